// File: rtl/seq_det_scheduler.sv
// rtl/seq_det_scheduler.sv - round-robin scheduler sharing one serial overlapping pattern detector
// Words are captured on grant, shifted MSB-first for W cycles, and reported with a per-word match count.
module seq_det_scheduler #(
    parameter int NCH = 4,
    parameter int W = 8,
    parameter int PW = 4,
    parameter logic [PW-1:0] DEFAULT_PATTERN = 4'b1010,
    parameter int CNT_W = 3,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     req,
    input  logic [NCH*W-1:0]   data_in,
    output logic [NCH-1:0]     ack,
    input  logic               cfg_we,
    input  logic [PW-1:0]      cfg_pattern,
    output logic [PW-1:0]      active_pattern,
    output logic               busy,
    output logic               ser_bit,
    output logic               ser_valid,
    output logic               match_pulse,
    output logic               done,
    output logic [CH_W-1:0]    done_ch,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int BC_W = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_ch;
    logic [W-1:0]      r_shreg;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [PW-2:0]     r_hist;
    logic [CNT_W-1:0]  r_cnt;
    logic [PW-1:0]     r_shadow;
    logic              r_pending;
    logic [PW-1:0]     r_active;
    logic [NCH-1:0]    r_ack;
    logic              r_match_pulse;
    logic              r_done;
    logic [CH_W-1:0]   r_done_ch;
    logic [CNT_W-1:0]  r_match_cnt;

    logic              w_found;
    logic [CH_W-1:0]   w_gnt;
    logic [W-1:0]      w_word;
    logic [PW-1:0]     w_window;
    logic              w_match;
    logic              w_last_bit;

    // Search rr_ptr+1 first; the k=NCH pass lands on rr_ptr itself, the lowest priority.
    always_comb begin
        logic [CH_W-1:0] idx;
        w_found = 1'b0;
        w_gnt   = '0;
        idx     = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = r_rr_ptr + CH_W'(k);
            if (req[idx]) begin
                w_found = 1'b1;
                w_gnt   = idx;
            end
        end
    end

    assign w_word     = data_in[w_gnt*W +: W];
    assign w_window   = {r_hist, r_shreg[W-1]};
    assign w_last_bit = (r_bit_cnt == BC_W'(W-1));
    assign w_match    = (r_state == S_SHIFT) && (r_bit_cnt >= BC_W'(PW-1))
                        && (w_window == r_active);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
        ser_valid = (r_state == S_SHIFT);
        ser_bit   = (r_state == S_SHIFT) ? r_shreg[W-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr      <= CH_W'(NCH-1);
            r_ch          <= '0;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_hist        <= '0;
            r_cnt         <= '0;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
            r_active      <= DEFAULT_PATTERN;
            r_ack         <= '0;
            r_match_pulse <= 1'b0;
            r_done        <= 1'b0;
            r_done_ch     <= '0;
            r_match_cnt   <= '0;
        end else begin
            r_ack         <= '0;
            r_done        <= 1'b0;
            r_match_pulse <= w_match;
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) r_active <= cfg_pattern;
                    if (w_found) begin
                        r_shreg   <= w_word;
                        r_ch      <= w_gnt;
                        r_ack     <= NCH'(1) << w_gnt;
                        r_bit_cnt <= '0;
                        r_hist    <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shreg   <= {r_shreg[W-2:0], 1'b0};
                    r_hist    <= w_window[PW-2:0];
                    r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    if (w_match && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
                    if (cfg_we) begin
                        r_shadow  <= cfg_pattern;
                        r_pending <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_done_ch   <= r_ch;
                    r_match_cnt <= r_cnt;
                    r_rr_ptr    <= r_ch;
                    // A write landing in DONE is newer than anything held in the shadow.
                    if (cfg_we)         r_active <= cfg_pattern;
                    else if (r_pending) r_active <= r_shadow;
                    r_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ack            = r_ack;
    assign active_pattern = r_active;
    assign match_pulse    = r_match_pulse;
    assign done           = r_done;
    assign done_ch        = r_done_ch;
    assign match_cnt      = r_match_cnt;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb/tb_seq_det_scheduler.sv - directed bench for seq_det_scheduler
module tb_seq_det_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        cfg_we;
    logic [3:0]  cfg_pattern;
    logic [3:0]  active_pattern;
    logic        busy;
    logic        ser_bit;
    logic        ser_valid;
    logic        match_pulse;
    logic        done;
    logic [1:0]  done_ch;
    logic [2:0]  match_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    seq_det_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .active_pattern(active_pattern),
        .busy(busy), .ser_bit(ser_bit), .ser_valid(ser_valid), .match_pulse(match_pulse),
        .done(done), .done_ch(done_ch), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [3:0] pat);
        cfg_we = 1'b1;
        cfg_pattern = pat;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_idle_pattern", active_pattern, pat);
    endtask

    // One complete word from a single requester; returns at the IDLE cycle that shows done.
    task automatic run_word(input int ch, input logic [7:0] d, input logic [3:0] pat_run,
                            input logic [3:0] pat_after, input int exp_cnt,
                            input int cfg_at, input logic [3:0] cfg_val, input int extra_req);
        int n;
        int pulses;
        logic [7:0] bits;
        logic sv_ok;
        req[ch] = 1'b1;
        data_in[ch*8 +: 8] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 20);
        check("ack_latency", n, 1);
        check("ack_onehot", ack, 32'(1) << ch);
        req[ch] = 1'b0;
        pulses = 0;
        sv_ok = 1'b1;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            bits[7-i] = ser_bit;
            if (!ser_valid) sv_ok = 1'b0;
            if (match_pulse) pulses++;
            if (i == cfg_at) begin
                cfg_we = 1'b1;
                cfg_pattern = cfg_val;
            end else begin
                cfg_we = 1'b0;
            end
        end
        @(negedge clk);
        cfg_we = 1'b0;
        if (match_pulse) pulses++;
        check("ser_bits", bits, d);
        check("ser_valid_shift", sv_ok, 1);
        check("busy_in_done", busy, 1);
        check("no_early_done", done, 0);
        check("pattern_during_word", active_pattern, pat_run);
        if (extra_req >= 0) req[extra_req] = 1'b1;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_ch", done_ch, ch);
        check("match_cnt", match_cnt, exp_cnt);
        check("match_pulses", pulses, exp_cnt);
        check("busy_idle", busy, 0);
        check("pattern_after_word", active_pattern, pat_after);
    endtask

    initial begin
        int n;
        int last_ack;
        reset = 1'b1;
        req = '0;
        data_in = '0;
        cfg_we = 1'b0;
        cfg_pattern = '0;
        last_ack = 0;
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_ser", {ser_valid, ser_bit, match_pulse, done}, 0);
        check("rst_done_ch", done_ch, 0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_pattern", active_pattern, 4'b1010);
        reset = 1'b0;

        // Basic word on ch0, default pattern 1010: AA yields three overlapping matches.
        run_word(0, 8'hAA, 4'hA, 4'hA, 3, -1, 4'h0, -1);

        set_cfg(4'b1111);
        run_word(2, 8'hFF, 4'hF, 4'hF, 5, -1, 4'h0, -1);
        set_cfg(4'b1010);
        run_word(2, 8'h0A, 4'hA, 4'hA, 1, -1, 4'h0, -1);

        // All four requesting continuously from reset: strict 0,1,2,3,0 at W+2 spacing.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        data_in = '0;
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (ack == 4'b0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("rr_grant", ack, 32'(1) << (g % 4));
            if (g > 0) check("ack_spacing", cyc - last_ack, 10);
            last_ack = cyc;
            repeat (9) @(negedge clk);
            check("rr_done", done, 1);
            check("rr_done_ch", done_ch, g % 4);
            check("rr_match_cnt", match_cnt, 0);
            if (g == 4) req = '0;
        end

        // Pattern write mid-word is deferred to the DONE->IDLE edge.
        run_word(1, 8'hAA, 4'hA, 4'h5, 3, 3, 4'b0101, -1);
        run_word(1, 8'h55, 4'h5, 4'h5, 3, -1, 4'h0, -1);

        // Reset in the middle of a ch3 word abandons it.
        req[3] = 1'b1;
        data_in[31:24] = 8'hAA;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 20);
        check("ch3_ack", ack, 4'b1000);
        req = '0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_outs", {ack, ser_valid, ser_bit, match_pulse, done}, 0);
        check("midrst_cnt", {done_ch, match_cnt}, 0);
        check("midrst_pattern", active_pattern, 4'b1010);
        repeat (10) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        reset = 1'b0;
        data_in = '0;
        req = 4'b1001;
        @(negedge clk);
        check("post_rst_grant", ack, 4'b0001);
        req = '0;
        n = 0;
        while (done == 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_done_lat", n, 9);
        check("post_rst_done_ch", done_ch, 0);

        // A request seen only during DONE is never granted.
        run_word(2, 8'h00, 4'hA, 4'hA, 0, -1, 4'h0, 1);
        req[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("pulse_req_no_ack", ack, 0);
        end
        // The same request held through IDLE is granted at the IDLE edge.
        run_word(2, 8'h00, 4'hA, 4'hA, 0, -1, 4'h0, 1);
        run_word(1, 8'h0A, 4'hA, 4'hA, 1, -1, 4'h0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
